// File: rtl/core_pkg.sv
// Shared definitions for multicycle_core: opcodes, funct codes, ALU ops, FSM states.
package core_pkg;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] LUI    = 7'h37;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITEBACK
  } state_t;

endpackage

// File: rtl/core_alu.sv
// Combinational integer ALU; shift amounts use the low $clog2(XLEN) bits of b.
module core_alu import core_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         alu_op,
  output logic [XLEN-1:0] result
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  // Select the operation result.
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I OP-IMM/OP/LUI core: FETCH -> DECODE -> EXECUTE -> WRITEBACK.
// Optional macro CORE_INSTRET_EN adds a 64-bit retired-instruction counter output.
module multicycle_core import core_pkg::*; #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NUM_REGS = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic            retire_valid,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic            illegal,
  output logic [XLEN-1:0] pc
`ifdef CORE_INSTRET_EN
  ,
  output logic [63:0]     instret
`endif
);

  localparam int unsigned IDXW = $clog2(NUM_REGS);

  state_t          state, state_next;
  logic [31:0]     ir;
  logic [XLEN-1:0] regs [NUM_REGS];
  logic [XLEN-1:0] op_a, op_b, result, alu_result;
  alu_op_t         op_q, dec_op;
  logic            ill_q, dec_ill;
  logic [XLEN-1:0] dec_a, dec_b, rs1_val, rs2_val, imm_i, imm_u;

  logic [6:0] opcode, f7, sh_hi;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];
  // With 64-bit shifts ir[25] is shamt[5], not part of the function code.
  assign sh_hi  = (XLEN == 64) ? {ir[31:26], 1'b0} : ir[31:25];

  assign imm_i   = XLEN'($signed(ir[31:20]));
  assign imm_u   = XLEN'($signed({ir[31:12], 12'h000}));
  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1[IDXW-1:0]];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2[IDXW-1:0]];

  assign imem_addr = pc;

  function automatic logic bad_reg(input logic [4:0] idx);
    return 32'(idx) >= NUM_REGS;
  endfunction

  core_alu #(.XLEN(XLEN)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .alu_op (op_q),
    .result (alu_result)
  );

  // Decode the latched instruction into operands, ALU op and legality.
  always_comb begin
    dec_op  = ALU_ADD;
    dec_a   = rs1_val;
    dec_b   = imm_i;
    dec_ill = 1'b0;
    case (opcode)
      OP_IMM: begin
        dec_ill = bad_reg(rd) | bad_reg(rs1);
        case (f3)
          F3_ADD:  dec_op = ALU_ADD;
          F3_SLL: begin
            dec_op = ALU_SLL;
            if (sh_hi != F7_BASE) dec_ill = 1'b1;
          end
          F3_SLT:  dec_op = ALU_SLT;
          F3_SLTU: dec_op = ALU_SLTU;
          F3_XOR:  dec_op = ALU_XOR;
          F3_SR: begin
            dec_op = (sh_hi == F7_ALT) ? ALU_SRA : ALU_SRL;
            if (sh_hi != F7_BASE && sh_hi != F7_ALT) dec_ill = 1'b1;
          end
          F3_OR:   dec_op = ALU_OR;
          default: dec_op = ALU_AND;
        endcase
      end
      OP: begin
        dec_b   = rs2_val;
        dec_ill = bad_reg(rd) | bad_reg(rs1) | bad_reg(rs2);
        if (f7 == F7_ALT) begin
          if (f3 != F3_ADD && f3 != F3_SR) dec_ill = 1'b1;
        end else if (f7 != F7_BASE) begin
          dec_ill = 1'b1;
        end
        case (f3)
          F3_ADD:  dec_op = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          F3_SLL:  dec_op = ALU_SLL;
          F3_SLT:  dec_op = ALU_SLT;
          F3_SLTU: dec_op = ALU_SLTU;
          F3_XOR:  dec_op = ALU_XOR;
          F3_SR:   dec_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          F3_OR:   dec_op = ALU_OR;
          default: dec_op = ALU_AND;
        endcase
      end
      LUI: begin
        dec_a   = '0;
        dec_b   = imm_u;
        dec_ill = bad_reg(rd);
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Next-state sequencing and the fetch request.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = rst_n;
        if (imem_valid) state_next = ST_DECODE;
      end
      ST_DECODE:    state_next = ST_EXECUTE;
      ST_EXECUTE:   state_next = ST_WRITEBACK;
      default:      state_next = ST_FETCH;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

  // Datapath registers, register file writes and retire/illegal pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      ir           <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_q         <= ALU_ADD;
      ill_q        <= 1'b0;
      result       <= '0;
      retire_valid <= 1'b0;
      retire_rd    <= '0;
      retire_data  <= '0;
      illegal      <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      retire_valid <= 1'b0;
      illegal      <= 1'b0;
      case (state)
        ST_FETCH: if (imem_valid) ir <= imem_rdata;
        ST_DECODE: begin
          op_a  <= dec_a;
          op_b  <= dec_b;
          op_q  <= dec_op;
          ill_q <= dec_ill;
        end
        ST_EXECUTE: result <= alu_result;
        default: begin
          pc <= pc + XLEN'(4);
          if (ill_q) begin
            illegal <= 1'b1;
          end else begin
            retire_valid <= 1'b1;
            retire_rd    <= rd;
            retire_data  <= (rd == 5'd0) ? '0 : result;
            if (rd != 5'd0) regs[rd[IDXW-1:0]] <= result;
          end
        end
      endcase
    end
  end

`ifdef CORE_INSTRET_EN
  // Count legal retirements only; illegal slots are not counted.
  always_ff @(posedge clk) begin
    if (!rst_n)                             instret <= '0;
    else if (state == ST_WRITEBACK && !ill_q) instret <= instret + 64'd1;
  end
`endif

endmodule
